// File: rtl/seg_scan.sv
// ----------------------------------------------------------------------------
// seg_scan -- multiplexed 7-segment display scanner
//
// Drives DIGITS common-anode/cathode digits by time-multiplexing one shared
// segment bus. Each digit owns a slot of SCAN_DIV clock cycles. The first
// cycle of every slot keeps all anodes dark so the previous digit's segment
// pattern cannot ghost onto the next digit.
//
// New display data is captured by `load` into a pending register. It is
// copied into the display register only at a frame boundary, so a frame is
// never torn between old and new data.
//
// Parameters
//   DIGITS     number of multiplexed digits (2..16)
//   SCAN_DIV   clock cycles per digit slot (>= 2)
//   ACTIVE_LOW 1 = seg/an outputs active-low, 0 = active-high
//
// Ports
//   clk        clock, all logic on rising edge
//   rst_n      synchronous active-low reset
//   value      4*DIGITS hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dot        decimal-point request per digit
//   blank      force digit dark (including its dp)
//   load       one-cycle strobe capturing value/dot/blank
//   seg        segments {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp (registered)
//   an         digit enables, at most one active (registered)
//   frame_tick one-cycle pulse in the cycle after each frame boundary
//   pending    captured data waiting for the next frame boundary
//
// Optional feature
//   SEG_SCAN_LZS_EN  when defined, leading-zero suppression is enabled: a
//                    digit whose nibble and all higher nibbles are zero and
//                    whose dot is clear is blanked. Digit 0 always shows.
//
// Handshake: `load` is a plain strobe with no back-pressure. Every cycle in
// which load=1 (and rst_n=1) is accepted; a later load overwrites a pending
// one that has not been shown yet.
// ----------------------------------------------------------------------------
module seg_scan #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dot,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // Inactive output levels, used during reset and as the blank level.
    localparam logic [7:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                               : {DIGITS{1'b0}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]    div_q,        div_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;

    logic [4*DIGITS-1:0] disp_val_q,   disp_val_d;
    logic [DIGITS-1:0]   disp_dot_q,   disp_dot_d;
    logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;

    logic [4*DIGITS-1:0] pend_val_q,   pend_val_d;
    logic [DIGITS-1:0]   pend_dot_q,   pend_dot_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                pending_q,    pending_d;

    logic [7:0]          seg_q,        seg_d;
    logic [DIGITS-1:0]   an_q,         an_d;
    logic                frame_tick_q, frame_tick_d;

    logic                frame_end;

    // ------------------------------------------------------------------
    // Hex to active-high segment pattern {a,b,c,d,e,f,g,dp}; dp left 0.
    // ------------------------------------------------------------------
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0:    pat = 8'hFC;
            4'h1:    pat = 8'h60;
            4'h2:    pat = 8'hDA;
            4'h3:    pat = 8'hF2;
            4'h4:    pat = 8'h66;
            4'h5:    pat = 8'hB6;
            4'h6:    pat = 8'hBE;
            4'h7:    pat = 8'hE0;
            4'h8:    pat = 8'hFE;
            4'h9:    pat = 8'hF6;
            4'hA:    pat = 8'hEE;
            4'hB:    pat = 8'h3E;
            4'hC:    pat = 8'h9C;
            4'hD:    pat = 8'h7A;
            4'hE:    pat = 8'h9E;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // Scan divider and digit index
    // ------------------------------------------------------------------
    assign frame_end = (div_q == DIV_LAST) && (idx_q == IDX_LAST);

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending / display registers
    // ------------------------------------------------------------------
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dot_d   = pend_dot_q;
        pend_blank_d = pend_blank_q;
        pending_d    = pending_q;
        disp_val_d   = disp_val_q;
        disp_dot_d   = disp_dot_q;
        disp_blank_d = disp_blank_q;

        if (load) begin
            pend_val_d   = value;
            pend_dot_d   = dot;
            pend_blank_d = blank;
            pending_d    = 1'b1;
        end

        if (frame_end) begin
            // A load landing exactly on the boundary is the newest data, so
            // it goes straight to the display and nothing is left pending.
            if (load) begin
                disp_val_d   = value;
                disp_dot_d   = dot;
                disp_blank_d = blank;
            end else if (pending_q) begin
                disp_val_d   = pend_val_q;
                disp_dot_d   = pend_dot_q;
                disp_blank_d = pend_blank_q;
            end
            pending_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression mask
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] suppress;

`ifdef SEG_SCAN_LZS_EN
    logic zero_run;

    // Walk from the most significant digit down; zero_run stays set while
    // every nibble seen so far (this one included) is zero.
    always_comb begin
        zero_run = 1'b1;
        suppress = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (disp_val_q[i*4 +: 4] == 4'h0);
            suppress[i] = (i != 0) && zero_run && !disp_dot_q[i];
        end
    end
`else
    assign suppress = '0;
`endif

    // ------------------------------------------------------------------
    // Current digit selection and output pattern
    // ------------------------------------------------------------------
    logic [3:0]        cur_nib;
    logic              cur_dot;
    logic              cur_dark;
    logic [DIGITS-1:0] an_hot;
    logic [7:0]        seg_raw;
    logic [DIGITS-1:0] an_raw;

    always_comb begin
        cur_nib  = 4'h0;
        cur_dot  = 1'b0;
        cur_dark = 1'b0;
        an_hot   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_val_q[i*4 +: 4];
                cur_dot   = disp_dot_q[i];
                cur_dark  = disp_blank_q[i] | suppress[i];
                an_hot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_raw    = hex_to_seg(cur_nib);
        seg_raw[0] = cur_dot;
        if (cur_dark) begin
            seg_raw = 8'h00;
        end

        // Count 0 of every slot is the anti-ghost guard: all digits dark.
        an_raw = (div_q == '0) ? '0 : an_hot;

        seg_d        = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        an_d         = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
        frame_tick_d = frame_end;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_dot_q   <= '0;
            disp_blank_q <= '0;
            pend_val_q   <= '0;
            pend_dot_q   <= '0;
            pend_blank_q <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dot_q   <= disp_dot_d;
            disp_blank_q <= disp_blank_d;
            pend_val_q   <= pend_val_d;
            pend_dot_q   <= pend_dot_d;
            pend_blank_q <= pend_blank_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan.sv
// ----------------------------------------------------------------------------
// tb_seg_scan -- directed table-driven bench for seg_scan
// (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1, so one frame is 16 cycles).
//
// The bench counts clock edges since reset release in `cyc`. After edge n
// the registered outputs reflect scanner state s = n-1, i.e. divider s%4 and
// digit (s/4)%4. A frame boundary is state s%16==15, so frame_tick is high
// after every edge with cyc%16==0, and new data is first visible in the
// frame that starts at the next edge.
// ----------------------------------------------------------------------------
module tb_seg_scan;

    localparam int DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dot;
    logic [3:0]  blank;
    logic        load;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    logic        pending;

    seg_scan #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dot        (dot),
        .blank      (blank),
        .load       (load),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock edge; checks anode scan and frame_tick against the cycle model.
    task automatic step();
        int         s;
        logic [3:0] hot;
        logic [3:0] exp_an;
        @(posedge clk);
        #1;
        cyc++;
        s      = cyc - 1;
        hot    = 4'b0001 << ((s / 4) % 4);
        exp_an = ((s % 4) == 0) ? 4'hF : ~hot;
        chk("an_scan", {28'd0, an}, {28'd0, exp_an});
        chk("frame_tick", {31'd0, frame_tick}, {31'd0, ((cyc % 16) == 0)});
    endtask

    // Step through one full frame checking seg on every non-guard cycle.
    task automatic run_frame(input logic [3:0][7:0] exp_seg);
        int s;
        for (int k = 0; k < 16; k++) begin
            step();
            s = cyc - 1;
            if ((s % 4) != 0) begin
                chk("seg_digit", {24'd0, seg}, {24'd0, exp_seg[(s / 4) % 4]});
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v;
        dot   = d;
        blank = b;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Run to the next frame boundary; pending must hold until exactly then.
    task automatic wait_boundary();
        while ((cyc % 16) != 0) begin
            step();
            if ((cyc % 16) != 0) chk("pending_hold", {31'd0, pending}, 32'd1);
            else                 chk("pending_drop", {31'd0, pending}, 32'd0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dt;
        logic [3:0]      bl;
        logic [3:0][7:0] exp_seg;   // [i] = expected seg for digit i
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, {8'h9F, 8'h25, 8'h0D, 8'h99}};
        vecs[1] = '{16'h8888, 4'b0001, 4'b0100, {8'h01, 8'hFF, 8'h01, 8'h00}};
`ifdef SEG_SCAN_LZS_EN
        vecs[2] = '{16'h0050, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'h49, 8'h03}};
        vecs[6] = '{16'h0000, 4'b0100, 4'b0000, {8'hFF, 8'h02, 8'hFF, 8'h03}};
`else
        vecs[2] = '{16'h0050, 4'b0000, 4'b0000, {8'h03, 8'h03, 8'h49, 8'h03}};
        vecs[6] = '{16'h0000, 4'b0100, 4'b0000, {8'h03, 8'h02, 8'h03, 8'h03}};
`endif
        vecs[3] = '{16'hABCD, 4'b0000, 4'b0000, {8'h11, 8'hC1, 8'h63, 8'h85}};
        vecs[4] = '{16'hEF09, 4'b1010, 4'b0000, {8'h60, 8'h71, 8'h02, 8'h09}};
        vecs[5] = '{16'h5678, 4'b0000, 4'b1000, {8'hFF, 8'h41, 8'h1F, 8'h01}};

        // ---------------- reset (load during reset must be dropped) -------
        rst_n = 1'b0;
        value = 16'hFFFF;
        dot   = 4'hF;
        blank = 4'h0;
        load  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg",        {24'd0, seg},        32'hFF);
        chk("rst_an",         {28'd0, an},         32'hF);
        chk("rst_pending",    {31'd0, pending},    32'd0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        rst_n = 1'b1;
        load  = 1'b0;
        cyc   = 0;

        // ---------------- table: load, wait boundary, check a frame -------
        for (int v = 0; v < 7; v++) begin
            do_load(vecs[v].val, vecs[v].dt, vecs[v].bl);
            chk("pending_set", {31'd0, pending}, 32'd1);
            wait_boundary();
            run_frame(vecs[v].exp_seg);
        end

        // ---------------- double load: only the last is shown ------------
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (3) step();
        do_load(16'h2222, 4'b0000, 4'b0000);
        chk("pending_dbl", {31'd0, pending}, 32'd1);
        wait_boundary();
        run_frame({8'h25, 8'h25, 8'h25, 8'h25});

        // ---------------- load exactly on the boundary cycle -------------
        while ((cyc % 16) != 15) step();
        do_load(16'h4321, 4'b0000, 4'b0000);
        chk("pending_bnd", {31'd0, pending}, 32'd0);
        run_frame({8'h99, 8'h0D, 8'h25, 8'h9F});

        // ---------------- mid-frame reset in slot 2 -----------------------
        repeat (10) step();
        rst_n = 1'b0;
        value = 16'h7777;
        load  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load  = 1'b0;
        cyc   = 0;
        chk("mid_rst_seg",     {24'd0, seg},        32'hFF);
        chk("mid_rst_an",      {28'd0, an},         32'hF);
        chk("mid_rst_pending", {31'd0, pending},    32'd0);
        chk("mid_rst_ft",      {31'd0, frame_tick}, 32'd0);
`ifdef SEG_SCAN_LZS_EN
        run_frame({8'hFF, 8'hFF, 8'hFF, 8'h03});
`else
        run_frame({8'h03, 8'h03, 8'h03, 8'h03});
`endif
        chk("post_rst_pending", {31'd0, pending}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
